// File: rtl/aes128_iter_encryptor_if.sv
// Request/response bundle for the iterative AES-128 encryptor.
// The master drives a block and key; the slave returns the cipher text.
interface aes128_iter_encryptor_if;
    logic         valid_in;
    logic [127:0] plain_text;
    logic [127:0] key_in;
    logic         ready;
    logic [127:0] cipher_text;
    logic         valid_out;
    logic [3:0]   round_number;

    modport master (
        output valid_in, plain_text, key_in,
        input  ready, cipher_text, valid_out, round_number
    );

    modport slave (
        input  valid_in, plain_text, key_in,
        output ready, cipher_text, valid_out, round_number
    );
endinterface

// File: rtl/aes128_iter_encryptor.sv
// Iterative AES-128 encryptor: one round per clock,
// round keys expanded on the fly alongside the state.
module aes128_iter_encryptor #(
    parameter int NR     = 10,
    parameter int DATA_W = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    aes128_iter_encryptor_if.slave bus
);

    typedef enum logic {S_IDLE, S_RUN} fsm_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so index from the MSB end.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    fsm_t              r_fsm, w_fsm_nxt;
    logic [DATA_W-1:0] r_state, r_key, r_ct;
    logic [3:0]        r_round;
    logic              r_vout;

    logic [7:0]        w_rcon;
    logic [31:0]       w_subw, w_k0, w_k1, w_k2, w_k3;
    logic [DATA_W-1:0] w_nkey, w_sb, w_sr, w_mc, w_rnd;
    logic              w_last;

    assign w_last = (r_round == 4'(NR));

    always_comb begin
        w_rcon = 8'h00;
        unique case (r_round)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // RotWord folded into the byte order fed to the four key S-boxes.
    assign w_subw = {sbox(r_key[23:16]), sbox(r_key[15:8]),
                     sbox(r_key[7:0]),   sbox(r_key[31:24])};
    assign w_k0   = r_key[127:96] ^ w_subw ^ {w_rcon, 24'h0};
    assign w_k1   = r_key[95:64] ^ w_k0;
    assign w_k2   = r_key[63:32] ^ w_k1;
    assign w_k3   = r_key[31:0]  ^ w_k2;
    assign w_nkey = {w_k0, w_k1, w_k2, w_k3};

    always_comb begin
        w_sb = '0;
        w_sr = '0;
        w_mc = '0;
        for (int i = 0; i < 16; i++) begin
            w_sb[127-8*i -: 8] = sbox(r_state[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127-8*(4*c+r) -: 8] =
                    w_sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mc[127-32*c -: 32] = mixcol(w_sr[127-32*c -: 32]);
        end
    end

    assign w_rnd = (w_last ? w_sr : w_mc) ^ w_nkey;

    always_ff @(posedge clk) begin
        if (rst) r_fsm <= S_IDLE;
        else     r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        unique case (r_fsm)
            S_IDLE:  if (bus.valid_in) w_fsm_nxt = S_RUN;
            S_RUN:   if (w_last)       w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
            r_key   <= '0;
            r_ct    <= '0;
            r_round <= '0;
            r_vout  <= 1'b0;
        end else begin
            r_vout <= 1'b0;
            unique case (r_fsm)
                S_IDLE: begin
                    if (bus.valid_in) begin
                        r_state <= bus.plain_text ^ bus.key_in;
                        r_key   <= bus.key_in;
                        r_round <= 4'd1;
                    end
                end
                S_RUN: begin
                    r_key   <= w_nkey;
                    r_state <= w_rnd;
                    if (w_last) begin
                        r_ct    <= w_rnd;
                        r_vout  <= 1'b1;
                        r_round <= 4'd0;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                default: r_round <= 4'd0;
            endcase
        end
    end

    assign bus.ready        = (r_fsm == S_IDLE);
    assign bus.cipher_text  = r_ct;
    assign bus.valid_out    = r_vout;
    assign bus.round_number = r_round;

endmodule

// File: tb/tb_aes128_iter_encryptor.sv
// Self-checking bench for aes128_iter_encryptor against a
// byte-array AES-128 model built from GF(2^8) arithmetic.
module tb_aes128_iter_encryptor;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    aes128_iter_encryptor_if bus ();

    aes128_iter_encryptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_AB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_AB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_AB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_ZER = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from multiplicative inverse plus affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
                  ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key,
                                             input logic [127:0] pt);
        logic [7:0]   w [44][4];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   a [4];
        logic [7:0]   rc;
        logic [7:0]   x;
        logic [127:0] out;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                w[i][j] = key[127-8*(4*i+j) -: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                x      = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[x];
                rc     = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++)
            s[i] = pt[127-8*i -: 8] ^ w[i/4][i%4];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
                    for (int r = 0; r < 4; r++)
                        s[4*c+r] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4])
                                 ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd+i/4][i%4];
        end
        out = '0;
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full block with per-round visibility checks.
    task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] exp);
        chk("ready_idle", bus.ready, 1'b1);
        bus.valid_in   = 1'b1;
        bus.key_in     = key;
        bus.plain_text = pt;
        tick();
        bus.valid_in = 1'b0;
        chk("ready_busy", bus.ready, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            chk("round_num", bus.round_number, k);
            chk("vout_early", bus.valid_out, 1'b0);
            tick();
        end
        chk("vout_lat10", bus.valid_out, 1'b1);
        chk("ct", bus.cipher_text, exp);
        chk("rn_done", bus.round_number, 4'd0);
        chk("ready_done", bus.ready, 1'b1);
        tick();
        chk("vout_pulse", bus.valid_out, 1'b0);
        chk("ct_hold", bus.cipher_text, exp);
    endtask

    initial begin
        logic [127:0] rk, rp, ct1;
        int           pulses, lat, k;

        total = 0;
        bad   = 0;
        build_sbox();
        rst            = 1'b1;
        bus.valid_in   = 1'b0;
        bus.key_in     = '0;
        bus.plain_text = '0;
        tick();
        tick();
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_vout", bus.valid_out, 1'b0);
        chk("rst_ct", bus.cipher_text, '0);
        chk("rst_rn", bus.round_number, '0);
        rst = 1'b0;
        tick();

        run_block(K_C1, P_C1, C_C1);
        run_block(K_AB, P_AB, C_AB);
        run_block('0, '0, C_ZER);

        for (int n = 0; n < 6; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            run_block(rk, rp, aes_ref(rk, rp));
        end

        // Busy rejection: second request at T0+3 must be ignored.
        bus.valid_in   = 1'b1;
        bus.key_in     = K_C1;
        bus.plain_text = P_C1;
        tick();
        bus.valid_in = 1'b0;
        tick();
        tick();
        bus.valid_in   = 1'b1;
        bus.key_in     = K_AB;
        bus.plain_text = {$urandom, $urandom, $urandom, $urandom};
        tick();
        bus.valid_in = 1'b0;
        pulses = 0;
        lat    = 0;
        ct1    = '0;
        for (int c = 4; c <= 25; c++) begin
            if (bus.valid_out) begin
                pulses++;
                lat = c - 1;
                ct1 = bus.cipher_text;
            end
            tick();
        end
        chk("busy_pulses", pulses, 1);
        chk("busy_lat", lat, 10);
        chk("busy_ct", ct1, C_C1);

        // Back-to-back with valid_in held high.
        bus.valid_in   = 1'b1;
        bus.key_in     = K_C1;
        bus.plain_text = P_C1;
        tick();
        bus.key_in     = K_AB;
        bus.plain_text = P_AB;
        k = 0;
        while (!bus.valid_out && k < 30) begin
            tick();
            k++;
        end
        chk("b2b_lat1", k, 10);
        chk("b2b_ct1", bus.cipher_text, C_C1);
        chk("b2b_ready", bus.ready, 1'b1);
        tick();
        bus.valid_in = 1'b0;
        chk("b2b_accept", bus.ready, 1'b0);
        k = 0;
        while (!bus.valid_out && k < 30) begin
            if (bus.cipher_text !== C_C1) chk("b2b_stable", bus.cipher_text, C_C1);
            tick();
            k++;
        end
        chk("b2b_lat2", k, 10);
        chk("b2b_ct2", bus.cipher_text, C_AB);
        tick();

        // Reset mid-run aborts the block.
        bus.valid_in   = 1'b1;
        bus.key_in     = K_AB;
        bus.plain_text = P_AB;
        tick();
        bus.valid_in = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_ready", bus.ready, 1'b1);
        chk("mid_ct", bus.cipher_text, '0);
        chk("mid_rn", bus.round_number, '0);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus.valid_out) pulses++;
            tick();
        end
        chk("mid_pulses", pulses, 0);
        run_block(K_C1, P_C1, C_C1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
